// File: rtl/fx_square_if.sv
// Ready/valid operand and result channels of the iterative fixed-point squarer.
// The slave side is the squarer; the master side is the producer/consumer.
interface fx_square_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sq_out;
  logic [TAG_W-1:0] tag_out;
  logic             ovf;

  modport slave (
    input  in_valid, a, tag_in, out_ready,
    output in_ready, out_valid, sq_out, tag_out, ovf
  );

  modport master (
    output in_valid, a, tag_in, out_ready,
    input  in_ready, out_valid, sq_out, tag_out, ovf
  );
endinterface

// File: rtl/fx_square_seq.sv
// Iterative signed fixed-point squarer: shift-add on |a|, round-half-up, saturate.
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CALC  | retiring BPC multiplier bits per cycle into the accumulator
// ROUND | rounding/saturating the exact product into sq_out
// DONE  | result presented until out_ready
module fx_square_seq #(
  parameter int WIDTH = 32,
  parameter int QINT  = 16,
  parameter int BPC   = 1,
  parameter int TAG_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  fx_square_if.slave  bus
);
  localparam int QFRAC = WIDTH - QINT;
  localparam int N     = WIDTH / BPC;
  localparam int CW    = $clog2(N + 1);
  localparam int PW    = 2 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PW:0]      HALF    = (PW+1)'(1) << (QFRAC - 1);
  localparam logic [WIDTH-1:0] SAT     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [PW:0]      SAT_EXT = {{(PW+1-WIDTH){1'b0}}, SAT};

  generate
    if ((WIDTH % BPC) != 0 || QFRAC < 1) begin : g_bad_cfg
      $error("fx_square_seq: WIDTH must be a multiple of BPC and QFRAC >= 1");
    end
  endgenerate

  logic [1:0]       state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [PW-1:0]    mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [PW-1:0]    acc_q,       acc_d;
  logic [TAG_W-1:0] tag_q,       tag_d;
  logic [WIDTH-1:0] sq_q,        sq_d;
  logic [TAG_W-1:0] tag_out_q,   tag_out_d;
  logic             ovf_q,       ovf_d;

  logic [WIDTH-1:0] mag;
  logic [PW-1:0]    add_term;
  logic [PW:0]      rounded;
  logic [PW:0]      r_shift;

  // Two's-complement magnitude; the most negative operand maps to 2^(WIDTH-1).
  assign mag = bus.a[WIDTH-1] ? ((~bus.a) + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.a;

  always_comb begin
    add_term = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier_q[i]) add_term = add_term + (mcand_q << i);
    end
  end

  // One extra bit keeps the rounding carry out of the top of the product.
  assign rounded = {1'b0, acc_q} + HALF;
  assign r_shift = rounded >> QFRAC;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    tag_d     = tag_q;
    sq_d      = sq_q;
    tag_out_d = tag_out_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, mag};
          mplier_d = mag;
          acc_d    = '0;
          tag_d    = bus.tag_in;
          cnt_d    = CW'(N);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = acc_q + add_term;
        mcand_d  = mcand_q << BPC;
        mplier_d = mplier_q >> BPC;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (r_shift > SAT_EXT) begin
          sq_d  = SAT;
          ovf_d = 1'b1;
        end else begin
          sq_d  = r_shift[WIDTH-1:0];
          ovf_d = 1'b0;
        end
        tag_out_d = tag_q;
        state_d   = S_DONE;
      end
      default: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      tag_q     <= '0;
      sq_q      <= '0;
      tag_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      tag_q     <= tag_d;
      sq_q      <= sq_d;
      tag_out_q <= tag_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sq_out    = sq_q;
  assign bus.tag_out   = tag_out_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fx_square_seq.sv
// Bench for fx_square_seq: vector table plus random operands through a scoreboard,
// with hand-written backpressure and mid-operation reset sequences.
module tb_fx_square_seq;
  localparam int LAT = 33;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  tag;
    logic [31:0] sq;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] sq;
    logic [7:0]  tag;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  fx_square_if #(.WIDTH(32), .TAG_W(8)) bus ();

  fx_square_seq #(.WIDTH(32), .QINT(16), .BPC(1), .TAG_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] av, input logic [7:0] tv);
    exp_t e;
    logic [63:0] m, p, r;
    m = {32'd0, av[31] ? (32'd0 - av) : av};
    p = m * m;
    r = (p + 64'd32768) >> 16;
    e.tag = tv;
    e.acc_cyc = 0;
    if (r > 64'h7FFF_FFFF) begin
      e.sq = 32'h7FFF_FFFF;
      e.ovf = 1'b1;
    end else begin
      e.sq = r[31:0];
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Monitor: inputs change #1 after posedge, so negedge values are what the next edge sees.
  initial begin : monitor
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.out_valid && !prev_ov) begin
          if (sb.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
          else chk("latency", 64'(cyc - sb[0].acc_cyc - 1), 64'(LAT));
        end
        if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("sq_out", 64'(bus.sq_out), 64'(e.sq));
          chk("tag_out", 64'(bus.tag_out), 64'(e.tag));
          chk("ovf", 64'(bus.ovf), 64'(e.ovf));
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [7:0] tv, input exp_t e_in);
    exp_t e;
    int w;
    bit ok;
    e = e_in;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.tag_in = tv;
    ok = 1'b0;
    for (w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("in_ready_after_done", 64'(bus.in_ready), 64'd1);
    chk("out_valid_after_done", 64'(bus.out_valid), 64'd0);
  endtask

  function automatic exp_t mk(input logic [31:0] sq, input logic [7:0] tv, input logic ov);
    exp_t e;
    e.sq = sq;
    e.tag = tv;
    e.ovf = ov;
    e.acc_cyc = 0;
    return e;
  endfunction

  initial begin : main
    vec_t vecs[12];
    logic [31:0] ra;
    logic [7:0]  rt;
    bit ok;

    vecs[0]  = '{32'h0002_0000, 8'h11, 32'h0004_0000, 1'b0};
    vecs[1]  = '{32'hFFFE_8000, 8'h12, 32'h0002_4000, 1'b0};
    vecs[2]  = '{32'h0000_00B5, 8'h13, 32'h0000_0000, 1'b0};
    vecs[3]  = '{32'h0000_00B6, 8'h14, 32'h0000_0001, 1'b0};
    vecs[4]  = '{32'h0000_0100, 8'h15, 32'h0000_0001, 1'b0};
    vecs[5]  = '{32'h00B5_0000, 8'h16, 32'h7FF9_0000, 1'b0};
    vecs[6]  = '{32'h00B6_0000, 8'h17, 32'h7FFF_FFFF, 1'b1};
    vecs[7]  = '{32'h8000_0000, 8'h18, 32'h7FFF_FFFF, 1'b1};
    vecs[8]  = '{32'h0000_0000, 8'h19, 32'h0000_0000, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 8'h1A, 32'h0000_0000, 1'b0};
    vecs[10] = '{32'h0000_8000, 8'h1B, 32'h0000_4000, 1'b0};
    vecs[11] = '{32'hFF4B_0000, 8'h1C, 32'h7FF9_0000, 1'b0};

    cyc = 0;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.tag_in = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sq_out", 64'(bus.sq_out), 64'd0);
    chk("rst_tag_out", 64'(bus.tag_out), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].tag, mk(vecs[i].sq, vecs[i].tag, vecs[i].ovf));
      wait_drain();
    end

    for (int i = 0; i < 8; i++) begin
      ra = (i < 4) ? $urandom() : $urandom_range(0, 32'h00FF_FFFF);
      if (i >= 4 && $urandom_range(0, 1) == 1) ra = 32'd0 - ra;
      rt = 8'(8'h40 + i);
      send(ra, rt, model(ra, rt));
      wait_drain();
    end

    // Backpressure: result held while a second operand waits upstream.
    bus.out_ready = 1'b0;
    send(32'h0002_0000, 8'h21, mk(32'h0004_0000, 8'h21, 1'b0));
    ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bp_out_valid_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a = 32'hFFFE_8000;
    bus.tag_in = 8'h22;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_sq_hold", 64'(bus.sq_out), 64'h0004_0000);
      chk("bp_tag_hold", 64'(bus.tag_out), 64'h21);
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid_hold", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bp_second_accept_timeout", 64'd0, 64'd1);
    else begin
      chk("bp_first_popped", 64'(sb.size()), 64'd0);
      sb.push_back(mk(32'h0002_4000, 8'h22, 1'b0));
      sb[sb.size()-1].acc_cyc = cyc;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain();

    // Reset ten cycles into CALC aborts the operation cleanly.
    send(32'h00B6_0000, 8'h31, mk(32'h7FFF_FFFF, 8'h31, 1'b1));
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_ovf", 64'(bus.ovf), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h0003_0000, 8'h32, mk(32'h0009_0000, 8'h32, 1'b0));
    wait_drain();

    repeat (40) @(negedge clk);
    chk("no_leftover_results", 64'(sb.size()), 64'd0);
    chk("idle_at_end", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
